// File: rtl/prg_arb_pkg.sv
// Shared definitions for the program-port arbiter: FSM state encoding and
// requester index constants. Used by prg_arb_pick2 and prg_port_arbiter.
package prg_arb_pkg;

  // FSM state encoding (one cycle in each non-idle state)
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  // Requester indices
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/prg_arb_pick2.sv
// Two-requester winner selection for the program-port arbiter.
// A lone requester always wins. On a tie the default build picks the
// requester that was not granted last (round-robin); with the macro
// PRG_ARB_FIXED_PRIO_EN defined, m0 always wins ties and 'last' is ignored.
module prg_arb_pick2
  import prg_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

`ifdef PRG_ARB_FIXED_PRIO_EN
  logic w_unusedLast;
  assign w_unusedLast = last;
`endif

  // Choose the winner index from the request pair and the tie-break rule
  always_comb begin
    grant = M0;
    case (req)
      2'b01:   grant = M0;
      2'b10:   grant = M1;
`ifdef PRG_ARB_FIXED_PRIO_EN
      2'b11:   grant = M0;
`else
      2'b11:   grant = (last == M0) ? M1 : M0;
`endif
      default: grant = M0;
    endcase
  end

endmodule

// File: rtl/prg_port_arbiter.sv
// Arbiter sharing RAM port b between two requesters (m0, m1).
// Each access walks IDLE -> ACCESS -> CAPTURE -> RESP, giving a fixed
// 3-cycle request-to-ack latency and one access every 4 cycles. Writes also
// return the RAM's old data. New grants are only made in program mode.
// Optional macro PRG_ARB_FIXED_PRIO_EN: fixed m0 tie priority, no last-grant
// register (default build uses round-robin tie-breaking).
module prg_port_arbiter
  import prg_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              prg_mode,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wd,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rd,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wd,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rd,
  output logic              prg_we,
  output logic [ADDR_W-1:0] prg_addr,
  output logic [DATA_W-1:0] prg_wd,
  input  logic [DATA_W-1:0] prg_rd
);

  logic [1:0]        r_state;
  logic              r_win;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wd;
  logic [DATA_W-1:0] r_m0Rd;
  logic [DATA_W-1:0] r_m1Rd;
  logic              w_last;
  logic              w_grant;
  logic              w_start;

  assign w_start = (r_state == ST_IDLE) && prg_mode && (m0_req || m1_req);

  prg_arb_pick2 u_pick (
    .req   ({m1_req, m0_req}),
    .last  (w_last),
    .grant (w_grant)
  );

`ifdef PRG_ARB_FIXED_PRIO_EN
  assign w_last = M1;
`else
  logic r_lastGrant;

  assign w_last = r_lastGrant;

  // Remember who was granted last; reset to m1 so m0 wins the first tie
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lastGrant <= M1;
    end else if (w_start) begin
      r_lastGrant <= w_grant;
    end
  end
`endif

  // Access sequencer: leaves IDLE only on a grant, then one cycle per state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    r_state <= w_start ? ST_ACCESS : ST_IDLE;
        ST_ACCESS:  r_state <= ST_CAPTURE;
        ST_CAPTURE: r_state <= ST_RESP;
        ST_RESP:    r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  // Latch the winner and its command so later req/data changes cannot disturb the access
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_win  <= M0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_wd   <= '0;
    end else if (w_start) begin
      r_win  <= w_grant;
      r_we   <= (w_grant == M1) ? m1_we   : m0_we;
      r_addr <= (w_grant == M1) ? m1_addr : m0_addr;
      r_wd   <= (w_grant == M1) ? m1_wd   : m0_wd;
    end
  end

  // Capture RAM read data into the winner's register; the loser's value is kept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m0Rd <= '0;
      r_m1Rd <= '0;
    end else if (r_state == ST_CAPTURE) begin
      if (r_win == M1) begin
        r_m1Rd <= prg_rd;
      end else begin
        r_m0Rd <= prg_rd;
      end
    end
  end

  // Drive the RAM port and the acks from the current state only
  always_comb begin
    prg_we   = 1'b0;
    prg_addr = '0;
    prg_wd   = '0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    case (r_state)
      ST_ACCESS: begin
        prg_we   = r_we;
        prg_addr = r_addr;
        prg_wd   = r_wd;
      end
      ST_CAPTURE: begin
        prg_addr = r_addr;
      end
      ST_RESP: begin
        m0_ack = (r_win == M0);
        m1_ack = (r_win == M1);
      end
      default: begin
        prg_we = 1'b0;
      end
    endcase
  end

  assign m0_rd = r_m0Rd;
  assign m1_rd = r_m1Rd;

endmodule

// File: doc/prg_port_arbiter.md
PRG_PORT_ARBITER -- requirements
Module: prg_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of requester and RAM addresses.
REQ-002 SHALL have parameter DATA_W, default 32, width of write/read data.
REQ-003 SHALL have port clk  input  1  single clock for all logic (same clock as the RAM port-b prg_clk).
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port prg_mode  input  1  1 = program mode (new requests accepted), 0 = run mode (no new grants).
REQ-006 SHALL have ports m0_req, m1_req  input  1  access request, held high until the matching ack.
REQ-007 SHALL have ports m0_we, m1_we  input  1  1 = write, 0 = read; stable while req is high.
REQ-008 SHALL have ports m0_addr, m1_addr  input  ADDR_W  byte address; stable while req is high.
REQ-009 SHALL have ports m0_wd, m1_wd  input  DATA_W  write data; stable while req is high.
REQ-010 SHALL have ports m0_ack, m1_ack  output  1  one-cycle completion pulse.
REQ-011 SHALL have ports m0_rd, m1_rd  output  DATA_W  read data, valid with ack and held until the next ack to the same requester.
REQ-012 SHALL have ports prg_we  output  1, prg_addr  output  ADDR_W, and prg_wd  output  DATA_W, driving RAM port b.
REQ-013 SHALL have port prg_rd  input  DATA_W  RAM port-b read data, valid one clk after its address is sampled.

Function
REQ-014 SHALL implement the FSM IDLE -> ACCESS -> CAPTURE -> RESP -> IDLE, one cycle per non-IDLE state.
REQ-015 IDLE SHALL leave IDLE only when prg_mode=1 and at least one req is high; at that edge it SHALL latch the winner index and the winner's we/addr/wd.
REQ-016 In ACCESS only, prg_addr/prg_wd SHALL carry the latched values and prg_we SHALL equal the latched we; in all other states prg_we SHALL be 0.
REQ-017 In CAPTURE, prg_addr SHALL hold the latched address, and prg_rd SHALL be registered into the winner's rd register at the end of the cycle, for both reads and writes (writes return the RAM old-data read).
REQ-018 In RESP, only the winner's ack SHALL be 1, with its rd register driving the output; the other requester's rd SHALL be unchanged.
REQ-019 Latency SHALL be fixed: req first high in cycle N with the FSM in IDLE -> ack in cycle N+3; throughput SHALL be one access per 4 cycles.
REQ-020 A req still high in the cycle after its ack SHALL be treated as a new request.
REQ-021 Arbitration SHALL be round-robin by default:
- a single requester wins;
- on a tie, the requester not granted last wins;
- the last-grant register updates at each IDLE->ACCESS transition.
REQ-022 prg_mode falling while not in IDLE SHALL NOT abort the access; the access completes, and the FSM then holds in IDLE.
REQ-023 A req dropped before its ack (protocol violation) SHALL NOT abort the access; the ack is still issued.

Reset
REQ-024 On reset_n=0, asynchronously:
- state=IDLE;
- m0_ack=m1_ack=0, prg_we=0;
- prg_addr, prg_wd, m0_rd and m1_rd all 0;
- the last-grant register = 1, so m0 wins the first tie.
REQ-025 Reset asserted mid-access SHALL drop the access with no ack; prg_we SHALL go to 0 immediately.

Configuration
REQ-026 With macro PRG_ARB_FIXED_PRIO_EN defined, m0 SHALL always win ties, and the last-grant register SHALL be absent; without it, round-robin per REQ-021 applies.

Structure
REQ-027 The shared package prg_arb_pkg SHALL hold:
- the FSM state encoding (IDLE=0, ACCESS=1, CAPTURE=2, RESP=3);
- the requester index constants M0=0, M1=1.
REQ-028 The winner selection SHALL be the sub-module prg_arb_pick2 (inputs req[1:0], last; output grant index), with the macro handled there.

Verification
REQ-029 Single read: m0 reads 0x0000_0010 while the RAM holds 0xDEAD_BEEF -> m0_ack in cycle N+3, m0_rd=0xDEAD_BEEF, prg_we never 1.
REQ-030 Single write: m1 writes 0x1234_5678 to 0x0000_0004 -> prg_we=1 for exactly one cycle (ACCESS), m1_ack at N+3, a later m0 read returns 0x1234_5678.
REQ-031 Tie: both req high after reset -> order m0, m1, m0, m1 (round-robin); with PRG_ARB_FIXED_PRIO_EN -> m0, m0, m0 while m0 keeps requesting.
REQ-032 prg_mode=0 with m0_req=1 -> no ack for 10 cycles; prg_mode->1 -> ack 3 cycles later.
REQ-033 prg_mode dropped in ACCESS -> the ack still occurs at N+3; a pending m1_req is not granted.
REQ-034 reset_n pulsed low in CAPTURE -> no ack, all outputs 0; the next request completes normally with 3-cycle latency.
